// File: rtl/echo_ind_serializer_pkg.sv
// Shared echo-path definitions: serializer state encoding and the default frame header.
package echo_ind_serializer_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hE1;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StB0,
        StB1,
        StB2,
        StB3
    } ser_state_e;

endpackage

// File: rtl/echo_ind_fifo.sv
// Circular FIFO buffering echo values ahead of the serializer.
module echo_ind_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO refuses writes even when a read happens in the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/echo_ind_serializer.sv
// Buffers echo indications and emits each 32-bit value as a header byte plus four
// little-endian data bytes on the downstream beat interface.
module echo_ind_serializer
    import echo_ind_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [7:0]  HDR   = HDR_DEFAULT
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   echo__ENA,
    input  logic [31:0]            echo_v,
    output logic                   echo__RDY,
    output logic                   out_beat__ENA,
    output logic [7:0]             out_beat_v,
    input  logic                   out_beat__RDY,
    output logic [$clog2(DEPTH):0] pending,
    output logic [15:0]            frames_sent
);

    ser_state_e  state_q, state_d;
    logic [31:0] frame_q, frame_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [31:0] head;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    echo_ind_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (echo__ENA),
        .wr_data (echo_v),
        .rd_en   (pop),
        .rd_data (head),
        .count   (pending),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign echo__RDY   = !fifo_full;
    assign frames_sent = frames_sent_q;

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        frames_sent_d = frames_sent_q;
        pop           = 1'b0;
        out_beat__ENA = 1'b0;
        out_beat_v    = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    frame_d = head;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                out_beat__ENA = out_beat__RDY;
                out_beat_v    = HDR;
                if (out_beat__RDY) state_d = StB0;
            end
            StB0: begin
                out_beat__ENA = out_beat__RDY;
                out_beat_v    = frame_q[7:0];
                if (out_beat__RDY) state_d = StB1;
            end
            StB1: begin
                out_beat__ENA = out_beat__RDY;
                out_beat_v    = frame_q[15:8];
                if (out_beat__RDY) state_d = StB2;
            end
            StB2: begin
                out_beat__ENA = out_beat__RDY;
                out_beat_v    = frame_q[23:16];
                if (out_beat__RDY) state_d = StB3;
            end
            StB3: begin
                out_beat__ENA = out_beat__RDY;
                out_beat_v    = frame_q[31:24];
                if (out_beat__RDY) begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    // Chain straight into the next header so frames run back to back.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        frame_d = head;
                        state_d = StHdr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            frame_q       <= '0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            frames_sent_q <= frames_sent_d;
        end
    end

endmodule

// File: tb/tb_echo_ind_serializer.sv
// Directed self-checking bench for echo_ind_serializer.
module tb_echo_ind_serializer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        echo_ena;
    logic [31:0] echo_v;
    logic        echo_rdy;
    logic        beat_ena;
    logic [7:0]  beat_v;
    logic        beat_rdy;
    logic [2:0]  pending;
    logic [15:0] frames_sent;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] beat_q[$];
    int         cyc_q[$];

    echo_ind_serializer #(
        .DEPTH (4),
        .HDR   (8'hE1)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .echo__ENA     (echo_ena),
        .echo_v        (echo_v),
        .echo__RDY     (echo_rdy),
        .out_beat__ENA (beat_ena),
        .out_beat_v    (beat_v),
        .out_beat__RDY (beat_rdy),
        .pending       (pending),
        .frames_sent   (frames_sent)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (beat_ena) begin
            beat_q.push_back(beat_v);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int k);
        logic [7:0] b;
        if (k == 0) b = 8'hE1;
        else b = v[8*(k-1) +: 8];
        return b;
    endfunction

    function automatic logic [31:0] get_beat(input int i);
        logic [31:0] r;
        if (i < beat_q.size()) r = {24'h0, beat_q[i]};
        else r = 32'hFFFF_FFFF;
        return r;
    endfunction

    task automatic clear_beats();
        beat_q.delete();
        cyc_q.delete();
    endtask

    // Compares the captured beat stream against the frames of vals[0..n-1].
    task automatic check_frames(input string tag, input logic [31:0] vals[8], input int n);
        check({tag, "_count"}, beat_q.size(), 5 * n);
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("%s_f%0d_b%0d", tag, f, k), get_beat(5 * f + k),
                      {24'h0, exp_byte(vals[f], k)});
            end
        end
    endtask

    logic [31:0] vals[8];
    int          t0;
    int          n_acc;

    initial begin
        RST      = 1'b1;
        echo_ena = 1'b0;
        echo_v   = '0;
        beat_rdy = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_echo_rdy", echo_rdy, 1);
        check("rst_beat_ena", beat_ena, 0);
        check("rst_beat_v", beat_v, 0);
        check("rst_pending", pending, 0);
        check("rst_frames", frames_sent, 0);

        // Single value: header two cycles after acceptance, last byte four cycles later.
        clear_beats();
        tick();
        echo_ena = 1'b1;
        echo_v   = 32'h1122_3344;
        t0       = cyc;
        tick();
        echo_ena = 1'b0;
        repeat (8) tick();
        vals[0] = 32'h1122_3344;
        check_frames("single", vals, 1);
        check("single_first_cyc", (cyc_q.size() > 0) ? cyc_q[0] : -1, t0 + 2);
        check("single_last_cyc", (cyc_q.size() > 4) ? cyc_q[4] : -1, t0 + 6);
        check("single_frames", frames_sent, 1);

        // Downstream ready toggling: each byte held until taken, no repeats.
        clear_beats();
        echo_ena = 1'b1;
        echo_v   = 32'hDEAD_BEEF;
        beat_rdy = 1'b1;
        tick();
        echo_ena = 1'b0;
        for (int j = 1; j < 16; j++) begin
            beat_rdy = (j % 2 == 0);
            tick();
        end
        beat_rdy = 1'b1;
        repeat (4) tick();
        vals[0] = 32'hDEAD_BEEF;
        check_frames("toggle", vals, 1);
        check("toggle_frames", frames_sent, 2);

        // Two values back to back: ten contiguous beats.
        clear_beats();
        echo_ena = 1'b1;
        echo_v   = 32'hA0B0_C0D0;
        tick();
        echo_v = 32'h0102_0304;
        tick();
        echo_ena = 1'b0;
        repeat (14) tick();
        vals[0] = 32'hA0B0_C0D0;
        vals[1] = 32'h0102_0304;
        check_frames("b2b", vals, 2);
        check("b2b_span", (cyc_q.size() > 9) ? cyc_q[9] - cyc_q[0] : -1, 9);
        check("b2b_frames", frames_sent, 4);

        // Fill with downstream stalled: one value moves into the frame register, four stay
        // buffered, then further pushes are refused.
        RST = 1'b1;
        tick();
        RST      = 1'b0;
        beat_rdy = 1'b0;
        clear_beats();
        n_acc = 0;
        for (int k = 0; k < 20 && echo_rdy; k++) begin
            vals[n_acc] = 32'h5A00_0010 + 32'(n_acc) * 32'h0101_0101;
            echo_ena    = 1'b1;
            echo_v      = vals[n_acc];
            n_acc++;
            tick();
        end
        echo_ena = 1'b0;
        check("full_accepted", n_acc, 5);
        @(negedge CLK);
        check("full_pending", pending, 4);
        check("full_echo_rdy", echo_rdy, 0);
        check("full_no_beats", beat_ena, 0);
        tick();
        echo_ena = 1'b1;
        echo_v   = 32'hDEAD_0000;
        tick();
        echo_ena = 1'b0;
        @(negedge CLK);
        check("full_ignored_pending", pending, 4);
        tick();
        beat_rdy = 1'b1;
        repeat (30) tick();
        check_frames("full", vals, 5);
        check("full_frames", frames_sent, 5);
        check("full_drained", pending, 0);

        // Reset during B1 with two values still queued.
        clear_beats();
        echo_ena = 1'b1;
        echo_v   = 32'h7766_5544;
        tick();
        echo_v = 32'h1111_1111;
        tick();
        echo_v = 32'h2222_2222;
        tick();
        echo_ena = 1'b0;
        tick();
        @(negedge CLK);
        check("midrst_pre_pending", pending, 2);
        check("midrst_pre_b1", beat_v, 8'h55);
        RST      = 1'b1;
        echo_ena = 1'b1;
        echo_v   = 32'h3333_3333;
        tick();
        RST      = 1'b0;
        echo_ena = 1'b0;
        @(negedge CLK);
        check("midrst_beat_ena", beat_ena, 0);
        check("midrst_beat_v", beat_v, 0);
        check("midrst_pending", pending, 0);
        check("midrst_frames", frames_sent, 0);
        check("midrst_echo_rdy", echo_rdy, 1);
        clear_beats();
        repeat (10) tick();
        check("midrst_quiet", beat_q.size(), 0);

        // Completed-frame counter wraps from FFFF to zero.
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge CLK);
        check("wrap_preload", frames_sent, 16'hFFFF);
        tick();
        release dut.frames_sent_q;
        @(negedge CLK);
        check("wrap_hold", frames_sent, 16'hFFFF);
        tick();
        echo_ena = 1'b1;
        echo_v   = 32'hCAFE_F00D;
        tick();
        echo_ena = 1'b0;
        repeat (8) tick();
        check("wrap_frames", frames_sent, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
